// File: rtl/alu_pkg.sv
// Shared opcode encoding and status bit positions for the pipelined arithmetic unit.
// No logic of its own: types and constants only.
// Not applicable: no handshake lives here.
package alu_pkg;

   localparam int ALU_OP_W = 2;

   typedef enum logic [1:0] {
      ALU_SUB  = 2'b00,
      ALU_COMP = 2'b01,
      ALU_SUM  = 2'b10,
      ALU_CONV = 2'b11
   } alu_op_e;

   localparam int ST_OVF = 0;
   localparam int ST_ZERO = 1;
   localparam int ST_NEG = 2;
   localparam int ST_ERR = 3;
   localparam int ST_W = 4;

endpackage

// File: rtl/sync_arith_core.sv
// Combinational core: {op, A, B} -> {result, status} for SUB, COMP, SUM and CONV.
// Zero cycles; sits between the S1 operand register and the S2 result register.
// No flow control: the surrounding pipeline decides when the output is captured.
module sync_arith_core
   import alu_pkg::*;
#(
   parameter int M = 8
) (
   input  alu_op_e          i_op,
   input  logic [M-1:0]     i_a,
   input  logic [M-1:0]     i_b,
   output logic [M-1:0]     o_result,
   output logic [ST_W-1:0]  o_status
);

   // M as an M-bit value so the SUM index test is a plain unsigned compare.
   localparam logic [M-1:0] M_VAL = M[M-1:0];
   localparam logic [M-1:0] MIN_NEG = {1'b1, {(M-1){1'b0}}};

   logic [M+1:0] sub_r;
   logic         sub_ovf;
   logic [M-1:0] sum_s;
   logic         sum_ovf;
   logic         b_in_range;
   logic [M-1:0] bit_mask;
   logic [M-2:0] conv_mag;
   logic         lt;
   logic         ovf;
   logic         err;
   logic [M-1:0] res;

   // Evaluate every op in parallel, then select result and OVF/ERR by opcode.
   always_comb begin
      // A - 2B in M+2 bits: 2B is B sign-extended by one bit and shifted left.
      sub_r      = {{2{i_a[M-1]}}, i_a} - {i_b[M-1], i_b, 1'b0};
      // In range only when the top three bits agree (pure sign extension).
      sub_ovf    = !((sub_r[M+1] == sub_r[M]) && (sub_r[M] == sub_r[M-1]));
      sum_s      = i_a + i_b;
      sum_ovf    = (i_a[M-1] == i_b[M-1]) && (sum_s[M-1] != i_a[M-1]);
      b_in_range = (i_b < M_VAL);
      bit_mask   = {{(M-1){1'b0}}, 1'b1} << i_b;
      // Low M-1 bits of -A; carries from the dropped sign bit never reach them.
      conv_mag   = (~i_a[M-2:0]) + {{(M-2){1'b0}}, 1'b1};
      lt         = ($signed(i_a) < $signed(i_b));
      ovf        = 1'b0;
      err        = 1'b0;
      res        = '0;
      case (i_op)
         ALU_SUB: begin
            res = sub_r[M-1:0];
            ovf = sub_ovf;
         end
         ALU_COMP: begin
            res = {{(M-1){1'b0}}, lt};
         end
         ALU_SUM: begin
            ovf = sum_ovf;
            if (b_in_range) begin
               res = sum_s & ~bit_mask;
            end else begin
               res = sum_s;
               err = 1'b1;
            end
         end
         ALU_CONV: begin
            if (!i_a[M-1]) begin
               res = i_a;
            end else if (i_a == MIN_NEG) begin
               // Most negative value has no sign-magnitude form: pass through, flag it.
               res = i_a;
               err = 1'b1;
            end else begin
               res = {1'b1, conv_mag};
            end
         end
         default: begin
            res = '0;
         end
      endcase
      o_result         = res;
      o_status         = '0;
      o_status[ST_OVF]  = ovf;
      o_status[ST_ZERO] = (res == '0);
      o_status[ST_NEG]  = res[M-1];
      o_status[ST_ERR]  = err;
   end

endmodule

// File: rtl/sync_arith_unit_pipe.sv
// Two-stage valid/ready arithmetic unit: S1 holds operands, S2 holds result+status; saturating error count.
// One edge into S1, one more into S2 (result visible after the second register); 1 beat/cycle.
// Stalls hold S2 stable; o_ready is combinational with no skid, so at most 2 beats are buffered.
module sync_arith_unit_pipe
   import alu_pkg::*;
#(
   parameter int N = ALU_OP_W,
   parameter int M = 8,
   parameter int C = 8
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [N-1:0]    i_op,
   input  logic [M-1:0]    i_arg_A,
   input  logic [M-1:0]    i_arg_B,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [M-1:0]    o_result,
   output logic [ST_W-1:0] o_status,
   output logic [C-1:0]    o_err_cnt
);

   logic            s1_v_q, s1_v_d;
   alu_op_e         s1_op_q, s1_op_d;
   logic [M-1:0]    s1_a_q, s1_a_d;
   logic [M-1:0]    s1_b_q, s1_b_d;
   logic            s2_v_q, s2_v_d;
   logic [M-1:0]    s2_res_q, s2_res_d;
   logic [ST_W-1:0] s2_st_q, s2_st_d;
   logic [C-1:0]    err_cnt_q, err_cnt_d;

   logic            s2_load;
   logic            s1_adv;
   logic            accept;
   logic            retire;
   logic [M-1:0]    core_res;
   logic [ST_W-1:0] core_st;

   sync_arith_core #(
      .M (M)
   ) u_core (
      .i_op     (s1_op_q),
      .i_a      (s1_a_q),
      .i_b      (s1_b_q),
      .o_result (core_res),
      .o_status (core_st)
   );

   // Handshake: S2 can take a beat when empty or draining; S1 can when empty or moving on.
   always_comb begin
      s2_load = !s2_v_q || i_ready;
      s1_adv  = s1_v_q && s2_load;
      o_ready = !s1_v_q || s2_load;
      accept  = i_valid && o_ready;
      retire  = s2_v_q && i_ready;
   end

   // Next state for both pipeline stages and the saturating error counter.
   always_comb begin
      s1_v_d    = s1_v_q;
      s1_op_d   = s1_op_q;
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
      s2_v_d    = s2_v_q;
      s2_res_d  = s2_res_q;
      s2_st_d   = s2_st_q;
      err_cnt_d = err_cnt_q;

      if (accept) begin
         s1_v_d  = 1'b1;
         s1_op_d = alu_op_e'(i_op);
         s1_a_d  = i_arg_A;
         s1_b_d  = i_arg_B;
      end else if (s1_adv) begin
         s1_v_d = 1'b0;
      end

      // Data is only replaced when a real beat arrives, so a drained S2 keeps its last value.
      if (s2_load) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_res_d = core_res;
            s2_st_d  = core_st;
         end
      end

      if (retire && (s2_st_q[ST_OVF] || s2_st_q[ST_ERR]) && (err_cnt_q != {C{1'b1}})) begin
         err_cnt_d = err_cnt_q + {{(C-1){1'b0}}, 1'b1};
      end
   end

   // State registers; reset drops any in-flight beats and clears the visible outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         s1_v_q    <= 1'b0;
         s1_op_q   <= ALU_SUB;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s2_v_q    <= 1'b0;
         s2_res_q  <= '0;
         s2_st_q   <= '0;
         err_cnt_q <= '0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_op_q   <= s1_op_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s2_v_q    <= s2_v_d;
         s2_res_q  <= s2_res_d;
         s2_st_q   <= s2_st_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign o_valid   = s2_v_q;
   assign o_result  = s2_res_q;
   assign o_status  = s2_st_q;
   assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_sync_arith_unit_pipe.sv
// Directed bench for sync_arith_unit_pipe (M=8) with a scoreboard queue of expected beats.
// A second instance with C=2 shares all inputs and is used for counter saturation.
// Every comparison is an immediate assertion; the run ends with one summary line.
module tb_sync_arith_unit_pipe;

   typedef struct packed {
      logic [7:0] r;
      logic [3:0] s;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       i_valid;
   logic       i_ready;
   logic [1:0] i_op;
   logic [7:0] i_a;
   logic [7:0] i_b;

   logic       o_ready, o_valid;
   logic [7:0] o_result;
   logic [3:0] o_status;
   logic [7:0] o_err_cnt;

   logic       o_ready2, o_valid2;
   logic [7:0] o_result2;
   logic [3:0] o_status2;
   logic [1:0] o_err_cnt2;

   exp_t sb[$];
   int   n_assert;
   int   n_fail;
   int   exp_err;
   int   exp_err2;

   sync_arith_unit_pipe #(.N(2), .M(8), .C(8)) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_op      (i_op),
      .i_arg_A   (i_a),
      .i_arg_B   (i_b),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_result  (o_result),
      .o_status  (o_status),
      .o_err_cnt (o_err_cnt)
   );

   sync_arith_unit_pipe #(.N(2), .M(8), .C(2)) dut_sat (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready2),
      .i_op      (i_op),
      .i_arg_A   (i_a),
      .i_arg_B   (i_b),
      .o_valid   (o_valid2),
      .i_ready   (i_ready),
      .o_result  (o_result2),
      .o_status  (o_status2),
      .o_err_cnt (o_err_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one beat, wait (bounded) for acceptance, record its expected output.
   task automatic drive(input string tag, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [3:0] es);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      i_valid = 1'b1;
      i_op    = op;
      i_a     = a;
      i_b     = b;
      while (!o_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " accept"}, (n < 50), 1);
      e.r = er;
      e.s = es;
      sb.push_back(e);
      @(posedge clk);
      #1 i_valid = 1'b0;
   endtask

   // Wait (bounded) for a result, compare with the scoreboard head, retire it, check counters.
   task automatic expect_out(input string tag);
      int n;
      exp_t e;
      n = 0;
      e = '0;
      while (!o_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " valid"}, o_valid, 1);
      chk({tag, " sb_nonempty"}, (sb.size() > 0), 1);
      if (sb.size() > 0) e = sb.pop_front();
      chk({tag, " result"}, o_result, e.r);
      chk({tag, " status"}, o_status, e.s);
      @(posedge clk);
      #1;
      if (e.s[0] || e.s[3]) begin
         if (exp_err < 255) exp_err++;
         if (exp_err2 < 3) exp_err2++;
      end
      chk({tag, " err_cnt"}, o_err_cnt, exp_err);
      chk({tag, " err_cnt_c2"}, o_err_cnt2, exp_err2);
   endtask

   initial begin
      exp_t e3;
      n_assert = 0;
      n_fail   = 0;
      exp_err  = 0;
      exp_err2 = 0;
      rst      = 1'b1;
      i_valid  = 1'b0;
      i_ready  = 1'b1;
      i_op     = 2'b00;
      i_a      = 8'h00;
      i_b      = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst o_valid", o_valid, 0);
      chk("rst o_result", o_result, 0);
      chk("rst o_status", o_status, 0);
      chk("rst o_err_cnt", o_err_cnt, 0);
      chk("rst o_ready", o_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      // Directed ops, one beat at a time
      drive("sub1", 2'b00, 8'h0A, 8'h03, 8'h04, 4'b0000); expect_out("sub1");
      drive("sub_ovf", 2'b00, 8'h80, 8'h01, 8'h7E, 4'b0001); expect_out("sub_ovf");
      drive("sub_min", 2'b00, 8'h00, 8'h40, 8'h80, 4'b0100); expect_out("sub_min");
      drive("comp_lt", 2'b01, 8'hFF, 8'h01, 8'h01, 4'b0000); expect_out("comp_lt");
      drive("comp_ge", 2'b01, 8'h01, 8'hFF, 8'h00, 4'b0010); expect_out("comp_ge");
      drive("sum_in", 2'b10, 8'h05, 8'h02, 8'h03, 4'b0000); expect_out("sum_in");
      drive("sum_err", 2'b10, 8'h05, 8'h09, 8'h0E, 4'b1000); expect_out("sum_err");
      drive("conv_neg", 2'b11, 8'hFB, 8'h00, 8'h85, 4'b0100); expect_out("conv_neg");
      drive("conv_min", 2'b11, 8'h80, 8'h00, 8'h80, 4'b1100); expect_out("conv_min");
      drive("conv_zero", 2'b11, 8'h00, 8'h00, 8'h00, 4'b0010); expect_out("conv_zero");

      // Backpressure: consumer stalls while three distinct beats are offered
      i_ready = 1'b0;
      drive("bp1", 2'b00, 8'h10, 8'h02, 8'h0C, 4'b0000);
      drive("bp2", 2'b01, 8'h80, 8'h7F, 8'h01, 4'b0000);
      i_valid = 1'b1;
      i_op    = 2'b10;
      i_a     = 8'h03;
      i_b     = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall o_ready", o_ready, 0);
         chk("stall o_valid", o_valid, 1);
         chk("stall o_result", o_result, 8'h0C);
         chk("stall o_status", o_status, 4'b0000);
      end
      i_ready = 1'b1;
      e3.r = 8'h02;
      e3.s = 4'b0000;
      sb.push_back(e3);
      expect_out("bp1");
      i_valid = 1'b0;
      expect_out("bp2");
      expect_out("bp3");

      // Back-to-back erroring beats: err_cnt reaches 5, C=2 instance holds at 3
      drive("burst_a", 2'b10, 8'h7F, 8'h01, 8'h80, 4'b0101);
      drive("burst_b", 2'b00, 8'h7F, 8'hC0, 8'hFF, 4'b0101);
      expect_out("burst_a");
      expect_out("burst_b");
      chk("sat c2 hold", o_err_cnt2, 3);
      chk("err_cnt five", o_err_cnt, 5);

      // Reset with two beats in flight
      i_ready = 1'b0;
      drive("inflight1", 2'b11, 8'hFB, 8'h00, 8'h85, 4'b0100);
      drive("inflight2", 2'b10, 8'h05, 8'h02, 8'h03, 4'b0000);
      @(negedge clk);
      chk("pre_rst o_valid", o_valid, 1);
      chk("pre_rst o_result", o_result, 8'h85);
      chk("pre_rst o_ready", o_ready, 0);
      #2 rst = 1'b1;
      #1;
      chk("async o_valid", o_valid, 0);
      chk("async o_result", o_result, 0);
      chk("async o_status", o_status, 0);
      chk("async o_err_cnt", o_err_cnt, 0);
      chk("async o_err_cnt_c2", o_err_cnt2, 0);
      sb.delete();
      exp_err  = 0;
      exp_err2 = 0;
      @(negedge clk);
      @(negedge clk);
      rst     = 1'b0;
      i_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst no_stale", o_valid, 0);
      end
      drive("post_rst", 2'b00, 8'h0A, 8'h03, 8'h04, 4'b0000);
      expect_out("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Hard stop in case a wait is ever left unbounded.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
